// File: rtl/node_mem_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : node_mem_defs (package)
// Description : Shared definitions for the node data-memory arbiter: memory
//               geometry, requester indices, memory-map bases, FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package node_mem_defs;

    // 2048x8 memory viewed as 16-bit words with an 11-bit byte address
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    // Requester slots on the arbiter
    localparam int REQ_BESTNB = 0;
    localparam int REQ_QUPD   = 1;
    localparam int REQ_PKT    = 2;
    localparam int REQ_CH     = 3;

    // Memory map used by the requesters
    localparam logic [ADDR_W-1:0] NBR_TBL_BASE = 11'h200;
    localparam logic [ADDR_W-1:0] Q_TBL_BASE   = 11'h2C0;
    localparam logic [ADDR_W-1:0] PKT_BUF_BASE = 11'h300;
    localparam logic [ADDR_W-1:0] CH_INFO_BASE = 11'h380;

    // Arbiter state encoding
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t S_IDLE = 1'b0;
    localparam arb_state_t S_OWN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/node_mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set finder. Searches upward
//               from i_last+1 (wrapping) over requests not in i_excl.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    input  logic [NUM_REQ-1:0] i_excl,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);

    logic [NUM_REQ-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Walk positions last+1 .. last+NUM_REQ; the first candidate wins
    always_comb begin
        int p;
        p       = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            p = (int'(i_last) + k) % NUM_REQ;
            if (!o_valid && w_cand[p]) begin
                o_valid = 1'b1;
                o_idx   = ID_W'(p);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/node_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : node_mem_arbiter
// Description : Round-robin arbiter and port mux sharing the node's
//               single-port data memory. An owner keeps the port until it
//               drops its request, so multi-access sequences are atomic.
// Revision    : 1.0 - initial release
// ============================================================================
module node_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ADDR_W   = node_mem_defs::ADDR_W,
    parameter int DATA_W   = node_mem_defs::DATA_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clock,
    input  logic                      nrst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_wr_en,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_wr_en,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      starve_err
);

    import node_mem_defs::*;

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]   C_LAST_RST = ID_W'(NUM_REQ - 1);

    arb_state_t          r_state,  w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt,    w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic                r_busy,   w_busy_nxt;
    logic [ID_W-1:0]     r_last,   w_last_nxt;
    logic [HOLD_W-1:0]   r_hold,   w_hold_nxt;
    logic                r_starve;

    logic                w_own;
    logic                w_owner_req;
    logic                w_starve_now;
    logic [ID_W-1:0]     w_pick_last;
    logic [NUM_REQ-1:0]  w_pick_excl;
    logic                w_pick_valid;
    logic [ID_W-1:0]     w_pick_idx;

    assign w_own       = (r_state == S_OWN);
    assign w_owner_req = req[r_gnt_id];

    // On a release edge the releaser becomes "last" and is excluded outright
    assign w_pick_last = w_own ? r_gnt_id : r_last;
    assign w_pick_excl = w_own ? r_gnt : '0;

    // Someone else is waiting while the owner has saturated its hold count
    assign w_starve_now = w_own && (r_hold == C_HOLD_MAX) && |(req & ~r_gnt);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (w_pick_last),
        .i_excl  (w_pick_excl),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // State register: FSM state, grant, round-robin pointer, hold counter, sticky starve flag
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_last   <= C_LAST_RST;
            r_hold   <= '0;
            r_starve <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
            r_last   <= w_last_nxt;
            r_hold   <= w_hold_nxt;
            r_starve <= r_starve | w_starve_now;
        end
    end

    // Next-state logic: grant from idle, hold while owner requests, hand over or go idle on release
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_busy_nxt   = r_busy;
        w_last_nxt   = r_last;
        w_hold_nxt   = r_hold;
        case (r_state)
            S_IDLE: begin
                if (en && w_pick_valid) begin
                    w_state_nxt  = S_OWN;
                    w_gnt_nxt    = NUM_REQ'(1) << w_pick_idx;
                    w_gnt_id_nxt = w_pick_idx;
                    w_busy_nxt   = 1'b1;
                    w_hold_nxt   = '0;
                end
            end
            S_OWN: begin
                if (w_owner_req) begin
                    if (r_hold != C_HOLD_MAX) begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end else begin
                    w_last_nxt = r_gnt_id;
                    w_hold_nxt = '0;
                    if (en && w_pick_valid) begin
                        w_gnt_nxt    = NUM_REQ'(1) << w_pick_idx;
                        w_gnt_id_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt  = S_IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                        w_busy_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: steer only the owner's port to memory, quiet when idle
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wr_en  = 1'b0;
        if (r_busy) begin
            mem_addr  = req_addr[r_gnt_id*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[r_gnt_id*DATA_W +: DATA_W];
            mem_wr_en = req_wr_en[r_gnt_id];
        end
        gnt        = r_gnt;
        gnt_id     = r_gnt_id;
        busy       = r_busy;
        rdata      = mem_rdata;
        starve_err = r_starve | w_starve_now;
    end

endmodule
`default_nettype wire

// File: tb/tb_node_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_mem_arbiter
// Description : Directed self-checking bench for node_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;

    logic                      clock = 1'b0;
    logic                      nrst;
    logic                      en;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_wr_en;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [ID_W-1:0]           gnt_id;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr_en;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         rdata;
    logic                      starve_err;

    int total = 0;
    int bad   = 0;

    node_mem_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (64)
    ) dut (
        .clock      (clock),
        .nrst       (nrst),
        .en         (en),
        .req        (req),
        .req_addr   (req_addr),
        .req_wr_en  (req_wr_en),
        .req_wdata  (req_wdata),
        .mem_rdata  (mem_rdata),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .rdata      (rdata),
        .starve_err (starve_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst      = 1'b0;
        en        = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_wr_en = '0;
        req_wdata = '0;
        mem_rdata = '0;
        tick();
        tick();
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_starve", 32'(starve_err), 32'h0);
        chk("rst_addr",   32'(mem_addr), 32'h0);
        chk("rst_we",     32'(mem_wr_en), 32'h0);

        // single request from requester 0
        nrst = 1'b1;
        en   = 1'b1;
        req  = 4'b0001;
        req_addr[0*ADDR_W +: ADDR_W] = 11'h2C4;
        mem_rdata = 16'hABCD;
        #1;
        chk("pre_edge_gnt", 32'(gnt), 32'h0);
        chk("rdata_pass",   32'(rdata), 32'hABCD);
        tick();
        chk("g0_gnt",   32'(gnt), 32'h1);
        chk("g0_id",    32'(gnt_id), 32'h0);
        chk("g0_busy",  32'(busy), 32'h1);
        chk("g0_addr",  32'(mem_addr), 32'h2C4);
        chk("g0_we",    32'(mem_wr_en), 32'h0);

        // round robin 0 -> 1 -> 2 -> 3 -> 0 with no bubble
        req = 4'b1111;
        tick();
        chk("rr_hold0", 32'(gnt), 32'h1);
        req = 4'b1110; tick(); req = 4'b1111;
        chk("rr_1_gnt", 32'(gnt), 32'h2);
        chk("rr_1_busy", 32'(busy), 32'h1);
        req = 4'b1101; tick(); req = 4'b1111;
        chk("rr_2_gnt", 32'(gnt), 32'h4);
        chk("rr_2_busy", 32'(busy), 32'h1);
        req = 4'b1011; tick(); req = 4'b1111;
        chk("rr_3_gnt", 32'(gnt), 32'h8);
        chk("rr_3_id",  32'(gnt_id), 32'h3);
        req = 4'b0111; tick(); req = 4'b1111;
        chk("rr_0_gnt", 32'(gnt), 32'h1);
        chk("rr_0_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("rr_idle_gnt",  32'(gnt), 32'h0);
        chk("rr_idle_busy", 32'(busy), 32'h0);

        // write isolation: owner 1 writes while requester 2 drives its write enable
        req_addr[1*ADDR_W +: ADDR_W]  = 11'h2F8;
        req_wdata[1*DATA_W +: DATA_W] = 16'h0005;
        req_wr_en[1] = 1'b1;
        req_addr[2*ADDR_W +: ADDR_W]  = 11'h308;
        req_wdata[2*DATA_W +: DATA_W] = 16'hFFFF;
        req_wr_en[2] = 1'b1;
        req = 4'b0110;
        tick();
        chk("wr_gnt",   32'(gnt), 32'h2);
        chk("wr_addr",  32'(mem_addr), 32'h2F8);
        chk("wr_data",  32'(mem_wdata), 32'h0005);
        chk("wr_we",    32'(mem_wr_en), 32'h1);
        req_wr_en[1] = 1'b0;
        #1;
        chk("wr_we_owner_off", 32'(mem_wr_en), 32'h0);
        req = 4'b0000;
        tick();
        chk("wr_idle_we",   32'(mem_wr_en), 32'h0);
        chk("wr_idle_addr", 32'(mem_addr), 32'h0);
        chk("wr_idle_data", 32'(mem_wdata), 32'h0);
        req_wr_en = '0;

        // enable gating
        en  = 1'b0;
        req = 4'b0010;
        tick();
        tick();
        chk("en0_gnt",  32'(gnt), 32'h0);
        chk("en0_busy", 32'(busy), 32'h0);
        en = 1'b1;
        tick();
        chk("en1_gnt", 32'(gnt), 32'h2);
        en  = 1'b0;
        req = 4'b1010;
        tick();
        chk("en_drop_hold", 32'(gnt), 32'h2);
        req = 4'b1000;
        tick();
        chk("en_drop_rel_gnt",  32'(gnt), 32'h0);
        chk("en_drop_rel_busy", 32'(busy), 32'h0);
        tick();
        chk("en_drop_stay", 32'(gnt), 32'h0);
        req = 4'b0000;
        en  = 1'b1;
        tick();

        // starvation: owner 0 holds while requester 2 waits
        req = 4'b0001;
        tick();
        chk("st_gnt", 32'(gnt), 32'h1);
        req = 4'b0101;
        for (int i = 0; i < 63; i++) tick();
        chk("st_63_flag", 32'(starve_err), 32'h0);
        tick();
        chk("st_64_flag", 32'(starve_err), 32'h1);
        chk("st_64_gnt",  32'(gnt), 32'h1);
        tick();
        tick();
        chk("st_nopreempt", 32'(gnt), 32'h1);
        req = 4'b0100;
        tick();
        chk("st_hand_gnt",  32'(gnt), 32'h4);
        chk("st_hand_flag", 32'(starve_err), 32'h1);
        req = 4'b0000;
        tick();
        chk("st_idle_flag", 32'(starve_err), 32'h1);
        chk("st_idle_busy", 32'(busy), 32'h0);

        // reset mid-grant
        req = 4'b0001;
        req_wr_en[0] = 1'b1;
        tick();
        chk("mr_gnt", 32'(gnt), 32'h1);
        chk("mr_we",  32'(mem_wr_en), 32'h1);
        req  = 4'b1001;
        nrst = 1'b0;
        tick();
        chk("mr_rst_gnt",    32'(gnt), 32'h0);
        chk("mr_rst_busy",   32'(busy), 32'h0);
        chk("mr_rst_we",     32'(mem_wr_en), 32'h0);
        chk("mr_rst_starve", 32'(starve_err), 32'h0);
        nrst = 1'b1;
        tick();
        chk("mr_after_gnt", 32'(gnt), 32'h1);
        chk("mr_after_id",  32'(gnt_id), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
